// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall controller: refill FSM states,
// the ResultSrc encoding that marks a load, the default refill line length,
// and a small helper for register-dependency matching.
package pipeline_pkg;

   // Refill controller states. DONE is a single-cycle completion state.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IREFILL = 2'd1,
      DREFILL = 2'd2,
      DONE    = 2'd3
   } refill_state_t;

   // ResultSrcE value that identifies a load instruction in Execute.
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // Default number of 32-bit beats per cache-line refill.
   localparam int BEATS_DEFAULT = 4;

   // True when a destination register creates a real dependency on a source.
   // x0 is hard-wired to zero, so it never creates a dependency.
   function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and stall/flush combination for the five-stage
// pipeline. Purely combinational; missStall_i comes from the refill controller.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic [4:0] Rs1D_i,
   input  logic [4:0] Rs2D_i,
   input  logic [4:0] RdE_i,
   input  logic [1:0] ResultSrcE_i,
   input  logic       PCSrcE_i,
   input  logic       missStall_i,
   output logic       StallF_o,
   output logic       StallD_o,
   output logic       StallE_o,
   output logic       StallM_o,
   output logic       StallW_o,
   output logic       FlushD_o,
   output logic       FlushE_o
);

   logic lwStall;

   // A load in Execute whose destination feeds Decode must hold Fetch/Decode
   // for one cycle and insert a bubble into Execute. A cache-miss stall freezes
   // the whole pipeline and suppresses flushes; a branch in Execute during
   // that freeze stays in the E register and is flushed once the freeze ends.
   always_comb begin
      lwStall  = (ResultSrcE_i == RESULT_SRC_LOAD) &
                 (regMatch(RdE_i, Rs1D_i) | regMatch(RdE_i, Rs2D_i));
      StallF_o = missStall_i | lwStall;
      StallD_o = missStall_i | lwStall;
      StallE_o = missStall_i;
      StallM_o = missStall_i;
      StallW_o = missStall_i;
      FlushD_o = PCSrcE_i & ~missStall_i;
      FlushE_o = (lwStall | PCSrcE_i) & ~missStall_i;
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: owns the cache-line refill FSM and beat counter
// shared by the I-cache and D-cache, and combines the resulting miss stall
// with load-use and branch hazards to drive the pipeline register enables.
module pipeline_stall_ctrl
   import pipeline_pkg::*;
#(
   parameter int BEATS = BEATS_DEFAULT
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4:0]               Rs1D_i,
   input  logic [4:0]               Rs2D_i,
   input  logic [4:0]               RdE_i,
   input  logic [1:0]               ResultSrcE_i,
   input  logic                     PCSrcE_i,
   input  logic                     ICacheMissF_i,
   input  logic                     DCacheMissM_i,
   input  logic                     MemValid_i,
   output logic                     MemReq_o,
   output logic                     MemSel_o,
   output logic [$clog2(BEATS)-1:0] BeatCnt_o,
   output logic                     RefillDoneI_o,
   output logic                     RefillDoneD_o,
   output logic                     StallF_o,
   output logic                     StallD_o,
   output logic                     StallE_o,
   output logic                     StallM_o,
   output logic                     StallW_o,
   output logic                     FlushD_o,
   output logic                     FlushE_o
);

   localparam int            CW        = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam logic [CW-1:0] ONE_BEAT  = CW'(1);

   refill_state_t state;
   refill_state_t nextState;
   logic          memSel;
   logic          nextSel;
   logic [CW-1:0] beatCnt;
   logic [CW-1:0] nextCnt;
   logic          memReq;
   logic          doneI;
   logic          doneD;
   logic          missStall;

   // Next-state logic. A D-miss wins over a simultaneous I-miss because the
   // Memory-stage instruction is older. Refill owner and beat counter are
   // captured on entry; the last valid beat wraps the counter and completes.
   // Any miss still asserted after DONE is picked up again from IDLE.
   always_comb begin
      nextState = state;
      nextSel   = memSel;
      nextCnt   = beatCnt;
      unique case (state)
         IDLE: begin
            if (DCacheMissM_i) begin
               nextState = DREFILL;
               nextSel   = 1'b1;
               nextCnt   = '0;
            end else if (ICacheMissF_i) begin
               nextState = IREFILL;
               nextSel   = 1'b0;
               nextCnt   = '0;
            end
         end
         IREFILL, DREFILL: begin
            if (MemValid_i) begin
               if (beatCnt == LAST_BEAT) begin
                  nextState = DONE;
                  nextCnt   = '0;
               end else begin
                  nextCnt = beatCnt + ONE_BEAT;
               end
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State and registered memory-side outputs. The request and completion
   // pulses are computed from the next state so they line up with the state
   // they belong to. Reset abandons any line in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         memSel  <= 1'b0;
         beatCnt <= '0;
         memReq  <= 1'b0;
         doneI   <= 1'b0;
         doneD   <= 1'b0;
      end else begin
         state   <= nextState;
         memSel  <= nextSel;
         beatCnt <= nextCnt;
         memReq  <= (nextState == IREFILL) || (nextState == DREFILL);
         doneI   <= (nextState == DONE) & ~nextSel;
         doneD   <= (nextState == DONE) & nextSel;
      end
   end

   // Miss stall takes effect in the same cycle the miss is raised. While
   // reset is held the FSM is treated as idle so the stall reflects only the
   // live miss inputs, even before the first reset edge has cleared state.
   always_comb begin
      missStall = ((state != IDLE) & ~rst) | DCacheMissM_i | ICacheMissF_i;
   end

   assign MemReq_o      = memReq;
   assign MemSel_o      = memSel;
   assign BeatCnt_o     = beatCnt;
   assign RefillDoneI_o = doneI;
   assign RefillDoneD_o = doneD;

   hazard_detect uHazard (
      .Rs1D_i       (Rs1D_i),
      .Rs2D_i       (Rs2D_i),
      .RdE_i        (RdE_i),
      .ResultSrcE_i (ResultSrcE_i),
      .PCSrcE_i     (PCSrcE_i),
      .missStall_i  (missStall),
      .StallF_o     (StallF_o),
      .StallD_o     (StallD_o),
      .StallE_o     (StallE_o),
      .StallM_o     (StallM_o),
      .StallW_o     (StallW_o),
      .FlushD_o     (FlushD_o),
      .FlushE_o     (FlushE_o)
   );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: a table of hazard vectors,
// hand-written refill sequences, and a randomized run compared every cycle
// against a behavioural model of the refill controller and hazard rules.
module tb_pipeline_stall_ctrl;

   localparam int BEATS = 4;
   localparam int CW    = $clog2(BEATS);

   logic          clk;
   logic          rst;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic [4:0]    rdE;
   logic [1:0]    resSrc;
   logic          pcSrc;
   logic          iMiss;
   logic          dMiss;
   logic          memValid;
   logic          memReq;
   logic          memSel;
   logic [CW-1:0] beatCnt;
   logic          doneI;
   logic          doneD;
   logic          stallF;
   logic          stallD;
   logic          stallE;
   logic          stallM;
   logic          stallW;
   logic          flushD;
   logic          flushE;

   int total  = 0;
   int passed = 0;

   // Behavioural model: a refill in progress, who owns it, how many beats
   // have arrived, and whether this is the completion cycle.
   bit mActive;
   bit mSelD;
   bit mDone;
   int mBeats;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [1:0] src;
      logic       pc;
      logic       expStallFD;
      logic       expStallEMW;
      logic       expFlushD;
      logic       expFlushE;
   } hazVec_t;

   hazVec_t vecs[9];

   pipeline_stall_ctrl #(.BEATS(BEATS)) dut (
      .clk           (clk),
      .rst           (rst),
      .Rs1D_i        (rs1),
      .Rs2D_i        (rs2),
      .RdE_i         (rdE),
      .ResultSrcE_i  (resSrc),
      .PCSrcE_i      (pcSrc),
      .ICacheMissF_i (iMiss),
      .DCacheMissM_i (dMiss),
      .MemValid_i    (memValid),
      .MemReq_o      (memReq),
      .MemSel_o      (memSel),
      .BeatCnt_o     (beatCnt),
      .RefillDoneI_o (doneI),
      .RefillDoneD_o (doneD),
      .StallF_o      (stallF),
      .StallD_o      (stallD),
      .StallE_o      (stallE),
      .StallM_o      (stallM),
      .StallW_o      (stallW),
      .FlushD_o      (flushD),
      .FlushE_o      (flushE)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
   endtask

   task automatic applyStimulus(input logic r, input logic d, input logic i, input logic v, input logic pc);
      rst      = r;
      dMiss    = d;
      iMiss    = i;
      memValid = v;
      pcSrc    = pc;
   endtask

   task automatic setHazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] rd, input logic [1:0] src);
      rs1    = a;
      rs2    = b;
      rdE    = rd;
      resSrc = src;
   endtask

   task automatic checkAgainstModel();
      bit miss;
      bit lw;
      miss = (!rst && (mActive || mDone)) || dMiss || iMiss;
      lw   = (resSrc == 2'b01) && (rdE != 0) && ((rdE == rs1) || (rdE == rs2));
      checkOutput("model StallF", stallF, miss || lw);
      checkOutput("model StallD", stallD, miss || lw);
      checkOutput("model StallE", stallE, miss);
      checkOutput("model StallM", stallM, miss);
      checkOutput("model StallW", stallW, miss);
      checkOutput("model FlushD", flushD, pcSrc && !miss);
      checkOutput("model FlushE", flushE, (lw || pcSrc) && !miss);
      checkOutput("model MemReq", memReq, mActive);
      checkOutput("model MemSel", memSel, mSelD);
      checkOutput("model BeatCnt", beatCnt, mBeats);
      checkOutput("model RefillDoneI", doneI, mDone && !mSelD);
      checkOutput("model RefillDoneD", doneD, mDone && mSelD);
   endtask

   task automatic modelClock();
      if (rst) begin
         mActive = 0;
         mSelD   = 0;
         mDone   = 0;
         mBeats  = 0;
      end else if (mDone) begin
         mDone = 0;
      end else if (mActive) begin
         if (memValid) begin
            mBeats = mBeats + 1;
            if (mBeats == BEATS) begin
               mBeats  = 0;
               mActive = 0;
               mDone   = 1;
            end
         end
      end else if (dMiss) begin
         mActive = 1;
         mSelD   = 1;
         mBeats  = 0;
      end else if (iMiss) begin
         mActive = 1;
         mSelD   = 0;
         mBeats  = 0;
      end
   endtask

   // Called just after a negedge with fresh inputs; checks, clocks, and
   // returns at the following negedge.
   task automatic runCycle();
      #1;
      checkAgainstModel();
      @(posedge clk);
      modelClock();
      @(negedge clk);
   endtask

   task automatic checkRegs(input string tag, input logic req, input logic sel, input int cnt,
                            input logic dI, input logic dD);
      checkOutput({tag, " MemReq"}, memReq, req);
      checkOutput({tag, " MemSel"}, memSel, sel);
      checkOutput({tag, " BeatCnt"}, beatCnt, cnt);
      checkOutput({tag, " RefillDoneI"}, doneI, dI);
      checkOutput({tag, " RefillDoneD"}, doneD, dD);
   endtask

   task automatic checkStalls(input string tag, input logic fd, input logic emw,
                              input logic fld, input logic fle);
      #1;
      checkOutput({tag, " StallF"}, stallF, fd);
      checkOutput({tag, " StallD"}, stallD, fd);
      checkOutput({tag, " StallE"}, stallE, emw);
      checkOutput({tag, " StallM"}, stallM, emw);
      checkOutput({tag, " StallW"}, stallW, emw);
      checkOutput({tag, " FlushD"}, flushD, fld);
      checkOutput({tag, " FlushE"}, flushE, fle);
   endtask

   initial begin
      bit pat[7];
      int expCnt[7];
      pat    = '{1, 0, 1, 0, 1, 0, 1};
      expCnt = '{0, 1, 1, 2, 2, 3, 3};

      vecs[0] = '{5'd5,  5'd0, 5'd5,  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{5'd5,  5'd0, 5'd0,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{5'd0,  5'd0, 5'd0,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{5'd3,  5'd7, 5'd7,  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{5'd5,  5'd6, 5'd5,  2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{5'd1,  5'd2, 5'd3,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{5'd4,  5'd4, 5'd9,  2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{5'd5,  5'd0, 5'd5,  2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[8] = '{5'd31, 5'd1, 5'd31, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      mActive = 0;
      mSelD   = 0;
      mDone   = 0;
      mBeats  = 0;
      setHazard(5'd0, 5'd0, 5'd0, 2'b00);
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);

      // Reset state, held for a couple of cycles.
      checkRegs("reset", 0, 0, 0, 0, 0);
      runCycle();
      runCycle();
      applyStimulus(0, 0, 0, 0, 0);

      // Hazard vector table with the refill FSM idle.
      for (int k = 0; k < 9; k++) begin
         setHazard(vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].src);
         applyStimulus(0, 0, 0, 0, vecs[k].pc);
         checkStalls($sformatf("vec%0d", k), vecs[k].expStallFD, vecs[k].expStallEMW,
                     vecs[k].expFlushD, vecs[k].expFlushE);
         runCycle();
      end
      setHazard(5'd0, 5'd0, 5'd0, 2'b00);

      // D-refill with gapped beats.
      applyStimulus(0, 1, 0, 0, 0);
      checkStalls("dmiss same cycle", 1, 1, 0, 0);
      runCycle();
      checkRegs("drefill entry", 1, 1, 0, 0, 0);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(0, 1, 0, pat[k], 0);
         checkRegs($sformatf("drefill step%0d", k), 1, 1, expCnt[k], 0, 0);
         runCycle();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("drefill done", 0, 1, 0, 0, 1);
      runCycle();
      checkRegs("drefill after done", 0, 1, 0, 0, 0);
      runCycle();

      // Simultaneous misses: D first, held I-miss served afterwards.
      applyStimulus(0, 1, 1, 0, 0);
      runCycle();
      checkRegs("both miss D first", 1, 1, 0, 0, 0);
      for (int k = 0; k < BEATS; k++) begin
         applyStimulus(0, 1, 1, 1, 0);
         runCycle();
      end
      applyStimulus(0, 0, 1, 0, 0);
      checkRegs("both miss D done", 0, 1, 0, 0, 1);
      runCycle();
      checkRegs("both miss idle gap", 0, 1, 0, 0, 0);
      checkStalls("both miss idle gap", 1, 1, 0, 0);
      runCycle();
      checkRegs("irefill start", 1, 0, 0, 0, 0);
      for (int k = 0; k < BEATS; k++) begin
         applyStimulus(0, 0, 1, 1, 0);
         runCycle();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("irefill done", 0, 0, 0, 1, 0);
      runCycle();

      // Branch resolved during a D-refill is flushed once the stall ends.
      applyStimulus(0, 1, 0, 0, 0);
      runCycle();
      for (int k = 0; k < BEATS; k++) begin
         applyStimulus(0, 1, 0, 1, 1);
         checkStalls($sformatf("branch in refill%0d", k), 1, 1, 0, 0);
         runCycle();
      end
      applyStimulus(0, 0, 0, 0, 1);
      checkStalls("branch in done", 1, 1, 0, 0);
      runCycle();
      checkStalls("branch released", 0, 0, 1, 1);
      runCycle();
      applyStimulus(0, 0, 0, 0, 0);
      runCycle();

      // Reset after two beats abandons the line; stray beats are ignored.
      applyStimulus(0, 1, 0, 0, 0);
      runCycle();
      applyStimulus(0, 1, 0, 1, 0);
      runCycle();
      runCycle();
      checkRegs("before reset", 1, 1, 2, 0, 0);
      applyStimulus(1, 1, 0, 1, 0);
      checkStalls("during reset", 1, 1, 0, 0);
      runCycle();
      checkRegs("after reset", 0, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 0, 0, 1, 0);
         checkRegs($sformatf("stray beat%0d", k), 0, 0, 0, 0, 0);
         runCycle();
      end

      // Randomized run against the behavioural model.
      for (int n = 0; n < 1500; n++) begin
         setHazard(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3) == 0);
         runCycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter: BEATS, 4, number of 32-bit memory beats per cache-line refill (power of two, >=2).
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- Rs1D_i, Rs2D_i  in  5  source registers of the instruction in Decode.
- RdE_i  in  5  destination register of the instruction in Execute.
- ResultSrcE_i  in  2  2'b01 marks a load in Execute.
- PCSrcE_i  in  1  taken branch or jump resolved in Execute.
- ICacheMissF_i  in  1  instruction-cache miss in Fetch.
- DCacheMissM_i  in  1  data-cache miss in Memory.
- MemValid_i  in  1  one refill beat is valid this cycle.
- MemReq_o  out  1  refill request to main memory.
- MemSel_o  out  1  refill owner: 0 is I-cache, 1 is D-cache.
- BeatCnt_o  out  log2(BEATS)  index of the current refill beat.
- RefillDoneI_o, RefillDoneD_o  out  1  one-cycle line-complete pulses.
- StallF_o, StallD_o, StallE_o, StallM_o, StallW_o  out  1  drive the active-low EN of each pipeline register; 1 means hold.
- FlushD_o, FlushE_o  out  1  clear the D and E pipeline registers.

Function
REQ-003 States: IDLE, IREFILL, DREFILL, DONE.
REQ-004 Transitions out of IDLE:
- to DREFILL if DCacheMissM_i=1;
- otherwise to IREFILL if ICacheMissF_i=1;
- otherwise remain in IDLE.
D-cache has priority when both misses occur in the same cycle.
REQ-005 On entry to IREFILL or DREFILL, MemSel_o is latched and BeatCnt_o is set to 0.
REQ-006 In IREFILL or DREFILL:
- MemReq_o is 1;
- each MemValid_i=1 cycle increments BeatCnt_o;
- the cycle with MemValid_i=1 and BeatCnt_o=BEATS-1 moves the FSM to DONE and wraps BeatCnt_o to 0.
REQ-007 MemValid_i is ignored in IDLE and in DONE.
REQ-008 DONE lasts exactly one cycle. In DONE, RefillDoneI_o or RefillDoneD_o (selected by MemSel_o) is 1 and MemReq_o is 0. DONE always returns to IDLE.
REQ-009 A miss still pending in IDLE after DONE starts a new refill. Example: an I-miss held during a D-refill goes to IREFILL on the cycle after DONE.
REQ-010 missStall = (state!=IDLE) | DCacheMissM_i | ICacheMissF_i. It is combinational, so it takes effect in the same cycle as the miss.
REQ-011 lwStall = (ResultSrcE_i==2'b01) & (RdE_i!=0) & ((RdE_i==Rs1D_i) | (RdE_i==Rs2D_i)).
REQ-012 Stall outputs:
- StallF_o = StallD_o = missStall | lwStall;
- StallE_o = StallM_o = StallW_o = missStall.
REQ-013 Flush outputs:
- FlushD_o = PCSrcE_i & ~missStall;
- FlushE_o = (lwStall | PCSrcE_i) & ~missStall.
REQ-014 A branch resolved while missStall is 1 is held in the E register. Its flush is therefore applied in the first cycle missStall returns to 0, not dropped.
REQ-015 Simultaneous lwStall and PCSrcE_i outside a miss stall: FlushD_o=1, FlushE_o=1, StallF_o=StallD_o=1.
REQ-016 MemReq_o, MemSel_o, BeatCnt_o and the RefillDone pulses are registered state. Stall and flush outputs are combinational.

Reset
REQ-017 With rst=1 at a clock edge: state is IDLE, BeatCnt_o=0, MemSel_o=0, MemReq_o=0, RefillDoneI_o=0, RefillDoneD_o=0.
REQ-018 Reset mid-refill abandons the line: MemReq_o=0 in the cycle after the reset edge, and no RefillDone pulse is issued.
REQ-019 While rst=1, stall and flush outputs still follow REQ-012 and REQ-013 from their inputs, with state treated as IDLE.

Structure
REQ-020 The state enum (IDLE/IREFILL/DREFILL/DONE), the load encoding 2'b01 and the BEATS default live in the shared package pipeline_pkg.
REQ-021 The load-use/flush logic (REQ-011 to REQ-013) is the sub-module hazard_detect; the FSM and counter stay in pipeline_stall_ctrl.

Verification
REQ-022 The bench covers these directed scenarios:
- Load-use: ResultSrcE_i=01, RdE_i=5, Rs1D_i=5 -> StallF/D=1, FlushE=1, StallE/M/W=0. Repeat with RdE_i=0 -> all stall and flush outputs 0.
- D-refill: DCacheMissM_i=1 in IDLE -> StallF..W=1 the same cycle, MemReq_o=1 and MemSel_o=1 next cycle. Four MemValid_i pulses with gaps -> BeatCnt_o 0,1,2,3, then DONE with RefillDoneD_o=1 for one cycle.
- Simultaneous I and D miss: D is served first. The I-miss stays asserted, and IREFILL with MemSel_o=0 starts the cycle after DONE.
- Branch during refill: PCSrcE_i=1 in DREFILL -> FlushD/E=0 throughout the stall; FlushD/E=1 in the first cycle both misses are deasserted in IDLE.
- Reset after beat 2: rst=1 -> next cycle IDLE, MemReq_o=0, BeatCnt_o=0, no RefillDone pulse. Extra MemValid_i pulses are ignored.
